// File: rtl/csrcounters_pkg.sv
// Shared constants and address-window decode for the counter CSR block.
// Used by the counter slice and by the top-level decode/read mux.
package csrcounters_pkg;

    localparam logic [11:0] MHPMCOUNTERBASE  = 12'hB00;
    localparam logic [11:0] MHPMCOUNTERHBASE = 12'hB80;
    localparam logic [11:0] HPMCOUNTERBASE   = 12'hC00;
    localparam logic [11:0] HPMCOUNTERHBASE  = 12'hC80;

    localparam int TIME    = 1;
    localparam int INSTRET = 2;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [2:0] {
        CSRC_NONE,
        CSRC_MLO,
        CSRC_MHI,
        CSRC_ULO,
        CSRC_UHI
    } csrc_region_e;

    // Each counter window is 32 entries, so the upper seven address bits pick the window.
    function automatic csrc_region_e decodeRegion(input logic [11:0] adr);
        csrc_region_e region;
        region = CSRC_NONE;
        if (adr[11:5] == MHPMCOUNTERBASE[11:5])
            region = CSRC_MLO;
        else if (adr[11:5] == MHPMCOUNTERHBASE[11:5])
            region = CSRC_MHI;
        else if (adr[11:5] == HPMCOUNTERBASE[11:5])
            region = CSRC_ULO;
        else if (adr[11:5] == HPMCOUNTERHBASE[11:5])
            region = CSRC_UHI;
        return region;
    endfunction

endpackage

// File: rtl/csrcounter_slice.sv
// One 64-bit event counter with increment enable and low/high half writes.
// A write in a cycle suppresses the increment; on RV32 the unwritten half holds.
module csrcounter_slice
    import csrcounters_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_incr,
    input  logic            i_wrLo,
    input  logic            i_wrHi,
    input  logic [XLEN-1:0] i_wrData,
    output logic [63:0]     o_count
);

    logic [63:0] r_count;
    logic [63:0] w_next;

    generate
        if (XLEN == 32) begin : g_rv32
            always_comb begin
                w_next = r_count;
                if (i_wrLo)
                    w_next[31:0] = i_wrData;
                if (i_wrHi)
                    w_next[63:32] = i_wrData;
                if (!i_wrLo && !i_wrHi && i_incr)
                    w_next = r_count + 64'd1;
            end
        end else begin : g_rv64
            // The high-half address does not exist on RV64, so that enable is dropped.
            logic w_unusedHi;
            assign w_unusedHi = i_wrHi;

            always_comb begin
                w_next = r_count;
                if (i_wrLo)
                    w_next = i_wrData;
                else if (i_incr)
                    w_next = r_count + 64'd1;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else
            r_count <= w_next;
    end

    assign o_count = r_count;

endmodule

// File: rtl/csrcounters.sv
// Machine/user counter CSRs: mcycle, minstret, mhpmcounterN and their user shadows,
// with privilege and counter-enable access checks feeding the M-stage read mux.
module csrcounters
    import csrcounters_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int COUNTERS    = 32,
    parameter int S_SUPPORTED = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            CSRWriteM,
    input  logic            UngatedCSRWriteM,
    input  logic [11:0]     CSRAdrM,
    input  logic [XLEN-1:0] CSRWriteValM,
    input  logic [1:0]      PrivilegeModeW,
    input  logic [31:0]     MCOUNTEREN_REGW,
    input  logic [31:0]     SCOUNTEREN_REGW,
    input  logic [31:0]     MCOUNTINHIBIT_REGW,
    input  logic [63:0]     MTIME,
    input  logic            InstrRetiredM,
    input  logic [31:0]     HPMEventM,
    output logic [XLEN-1:0] CSRCReadValM,
    output logic            IllegalCSRCAccessM
);

    logic [4:0]      w_idx;
    csrc_region_e    w_region;
    logic            w_isM;
    logic            w_isU;
    logic            w_isHi;
    logic            w_illegal;
    logic            w_wrLo;
    logic            w_wrHi;
    logic [31:0]     w_incr;
    logic [63:0]     w_counters [32];
    logic [63:0]     w_sel;
    logic [XLEN-1:0] w_readLo;
    logic [XLEN-1:0] w_readHi;
    logic [XLEN-1:0] w_timeLo;
    logic [XLEN-1:0] w_timeHi;
    logic            w_unused;

    assign w_idx    = CSRAdrM[4:0];
    assign w_region = decodeRegion(CSRAdrM);
    assign w_isM    = (w_region == CSRC_MLO) || (w_region == CSRC_MHI);
    assign w_isU    = (w_region == CSRC_ULO) || (w_region == CSRC_UHI);
    assign w_isHi   = (w_region == CSRC_MHI) || (w_region == CSRC_UHI);

    // Index 1 is time, never a counter; the other low indices have dedicated event sources.
    always_comb begin
        w_incr    = HPMEventM & ~MCOUNTINHIBIT_REGW;
        w_incr[0] = ~MCOUNTINHIBIT_REGW[0];
        w_incr[1] = 1'b0;
        w_incr[2] = InstrRetiredM & ~MCOUNTINHIBIT_REGW[INSTRET];
    end

    always_comb begin
        w_illegal = 1'b0;
        if (w_isHi && (XLEN == 64))
            w_illegal = 1'b1;
        if (w_isM) begin
            if (w_idx == 5'(TIME))
                w_illegal = 1'b1;
            if (PrivilegeModeW != PRIV_M)
                w_illegal = 1'b1;
        end
        if (w_isU) begin
            if (UngatedCSRWriteM)
                w_illegal = 1'b1;
            if ((PrivilegeModeW == PRIV_S) && !MCOUNTEREN_REGW[w_idx])
                w_illegal = 1'b1;
            if ((PrivilegeModeW == PRIV_U) && !MCOUNTEREN_REGW[w_idx])
                w_illegal = 1'b1;
            if ((PrivilegeModeW == PRIV_U) && (S_SUPPORTED != 0) && !SCOUNTEREN_REGW[w_idx])
                w_illegal = 1'b1;
        end
    end

    // Only the machine windows are writable; the user shadows never touch storage.
    assign w_wrLo = CSRWriteM && (w_region == CSRC_MLO) && !w_illegal;
    assign w_wrHi = CSRWriteM && (w_region == CSRC_MHI) && !w_illegal;

    generate
        for (genvar i = 0; i < 32; i++) begin : g_cnt
            if ((i == TIME) || (i >= COUNTERS)) begin : g_zero
                assign w_counters[i] = '0;
            end else begin : g_slice
                csrcounter_slice #(
                    .XLEN(XLEN)
                ) u_slice (
                    .clk     (clk),
                    .reset   (reset),
                    .i_incr  (w_incr[i]),
                    .i_wrLo  (w_wrLo && (w_idx == 5'(i))),
                    .i_wrHi  (w_wrHi && (w_idx == 5'(i))),
                    .i_wrData(CSRWriteValM),
                    .o_count (w_counters[i])
                );
            end
        end
    endgenerate

    assign w_sel    = w_counters[w_idx];
    assign w_readLo = w_sel[XLEN-1:0];
    assign w_timeLo = MTIME[XLEN-1:0];

    generate
        if (XLEN == 32) begin : g_hi32
            assign w_readHi = w_sel[63:32];
            assign w_timeHi = MTIME[63:32];
        end else begin : g_hi64
            assign w_readHi = '0;
            assign w_timeHi = '0;
        end
    endgenerate

    always_comb begin
        CSRCReadValM = '0;
        if (!w_illegal) begin
            case (w_region)
                CSRC_MLO: CSRCReadValM = w_readLo;
                CSRC_MHI: CSRCReadValM = w_readHi;
                CSRC_ULO: CSRCReadValM = (w_idx == 5'(TIME)) ? w_timeLo : w_readLo;
                CSRC_UHI: CSRCReadValM = (w_idx == 5'(TIME)) ? w_timeHi : w_readHi;
                default:  CSRCReadValM = '0;
            endcase
        end
    end

    assign IllegalCSRCAccessM = w_illegal;

    assign w_unused = ^{MCOUNTINHIBIT_REGW, MTIME, w_sel, SCOUNTEREN_REGW, HPMEventM, w_incr};

endmodule

// File: tb/tb_csrcounters.sv
// Self-checking bench for csrcounters: an RV64 instance (8 counters) and an RV32
// instance (32 counters) driven from shared stimulus, checked through a scoreboard.
module tb_csrcounters;
    import csrcounters_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        CSRWriteM;
    logic        UngatedCSRWriteM;
    logic [11:0] CSRAdrM;
    logic [63:0] CSRWriteValM;
    logic [1:0]  PrivilegeModeW;
    logic [31:0] MCOUNTEREN_REGW;
    logic [31:0] SCOUNTEREN_REGW;
    logic [31:0] MCOUNTINHIBIT_REGW;
    logic [63:0] MTIME;
    logic        InstrRetiredM;
    logic [31:0] HPMEventM;
    logic [63:0] rd64;
    logic        ill64;
    logic [31:0] rd32;
    logic        ill32;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        bit          rv32;
        logic [63:0] expVal;
        logic        expIll;
    } exp_t;

    typedef struct {
        logic [11:0] adr;
        logic [1:0]  priv;
        logic [31:0] mcen;
        logic [31:0] scen;
        logic        ungated;
        bit          rv32;
        logic [63:0] expVal;
        logic        expIll;
    } vec_t;

    exp_t expQ[$];
    vec_t vecs[23];

    always #5 clk = ~clk;

    csrcounters #(.XLEN(64), .COUNTERS(8), .S_SUPPORTED(1)) dut (
        .clk               (clk),
        .reset             (reset),
        .CSRWriteM         (CSRWriteM),
        .UngatedCSRWriteM  (UngatedCSRWriteM),
        .CSRAdrM           (CSRAdrM),
        .CSRWriteValM      (CSRWriteValM),
        .PrivilegeModeW    (PrivilegeModeW),
        .MCOUNTEREN_REGW   (MCOUNTEREN_REGW),
        .SCOUNTEREN_REGW   (SCOUNTEREN_REGW),
        .MCOUNTINHIBIT_REGW(MCOUNTINHIBIT_REGW),
        .MTIME             (MTIME),
        .InstrRetiredM     (InstrRetiredM),
        .HPMEventM         (HPMEventM),
        .CSRCReadValM      (rd64),
        .IllegalCSRCAccessM(ill64)
    );

    csrcounters #(.XLEN(32), .COUNTERS(32), .S_SUPPORTED(1)) dut32 (
        .clk               (clk),
        .reset             (reset),
        .CSRWriteM         (CSRWriteM),
        .UngatedCSRWriteM  (UngatedCSRWriteM),
        .CSRAdrM           (CSRAdrM),
        .CSRWriteValM      (CSRWriteValM[31:0]),
        .PrivilegeModeW    (PrivilegeModeW),
        .MCOUNTEREN_REGW   (MCOUNTEREN_REGW),
        .SCOUNTEREN_REGW   (SCOUNTEREN_REGW),
        .MCOUNTINHIBIT_REGW(MCOUNTINHIBIT_REGW),
        .MTIME             (MTIME),
        .InstrRetiredM     (InstrRetiredM),
        .HPMEventM         (HPMEventM),
        .CSRCReadValM      (rd32),
        .IllegalCSRCAccessM(ill32)
    );

    task automatic checkOutput();
        exp_t        e;
        logic [63:0] actVal;
        logic        actIll;
        #1;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard: no expectation queued, got val=0x%h", rd64);
            return;
        end
        e = expQ.pop_front();
        if (e.rv32) begin
            actVal = {32'h0, rd32};
            actIll = ill32;
        end else begin
            actVal = rd64;
            actIll = ill64;
        end
        if ((actVal !== e.expVal) || (actIll !== e.expIll)) begin
            failures++;
            $display("[TB] FAIL %s: got val=0x%h ill=%b, expected val=0x%h ill=%b",
                     e.name, actVal, actIll, e.expVal, e.expIll);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [11:0] adr, input logic [1:0] priv,
                                 input bit rv32, input logic [63:0] expVal, input logic expIll);
        exp_t e;
        CSRAdrM        = adr;
        PrivilegeModeW = priv;
        e.name   = name;
        e.rv32   = rv32;
        e.expVal = expVal;
        e.expIll = expIll;
        expQ.push_back(e);
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Frozen-counter vectors: d64 c0=0x100000004, c2=0x101, c3=20; d32 c0=4, c2=0x101, c3=20.
        vecs[0]  = '{12'hB00, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b0, 64'h1_0000_0004, 1'b0};
        vecs[1]  = '{12'hB02, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b0, 64'h101, 1'b0};
        vecs[2]  = '{12'hC02, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b0, 64'h101, 1'b0};
        vecs[3]  = '{12'hB03, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b0, 64'h14, 1'b0};
        vecs[4]  = '{12'hC03, PRIV_U, 32'h8, 32'h8, 1'b0, 1'b0, 64'h14, 1'b0};
        vecs[5]  = '{12'hC03, PRIV_U, 32'h8, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1};
        vecs[6]  = '{12'hC03, PRIV_S, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1};
        vecs[7]  = '{12'hC03, PRIV_S, 32'h8, 32'h0, 1'b0, 1'b0, 64'h14, 1'b0};
        vecs[8]  = '{12'hB80, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1};
        vecs[9]  = '{12'hC85, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1};
        vecs[10] = '{12'hB1F, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0};
        vecs[11] = '{12'hB08, PRIV_M, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0};
        vecs[12] = '{12'h300, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0};
        vecs[13] = '{12'hB00, PRIV_U, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 1'b1};
        vecs[14] = '{12'hB80, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b0};
        vecs[15] = '{12'hC00, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b1, 64'h4, 1'b0};
        vecs[16] = '{12'hC81, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1};
        vecs[17] = '{12'hC01, PRIV_U, 32'h2, 32'h2, 1'b0, 1'b0, 64'h1_2345_6789, 1'b0};
        vecs[18] = '{12'hC01, PRIV_U, 32'h2, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1};
        vecs[19] = '{12'hB81, PRIV_M, 32'h0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b1};
        vecs[20] = '{12'hC02, PRIV_M, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1};
        vecs[21] = '{12'hC83, PRIV_U, 32'h8, 32'h8, 1'b0, 1'b1, 64'h0, 1'b0};
        vecs[22] = '{12'hB01, PRIV_U, 32'h0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b1};

        reset              = 1'b1;
        CSRWriteM          = 1'b0;
        UngatedCSRWriteM   = 1'b0;
        CSRAdrM            = 12'hB00;
        CSRWriteValM       = '0;
        PrivilegeModeW     = PRIV_M;
        MCOUNTEREN_REGW    = '0;
        SCOUNTEREN_REGW    = '0;
        MCOUNTINHIBIT_REGW = '0;
        MTIME              = 64'h1_2345_6789;
        InstrRetiredM      = 1'b0;
        HPMEventM          = '0;

        // Reset state, then ten free-running cycles.
        repeat (2) @(negedge clk);
        applyStimulus("reset_mcycle64", 12'hB00, PRIV_M, 1'b0, 64'h0, 1'b0);
        applyStimulus("reset_mcycle32", 12'hB00, PRIV_M, 1'b1, 64'h0, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        applyStimulus("mcycle_10", 12'hB00, PRIV_M, 1'b0, 64'd10, 1'b0);
        applyStimulus("mcycle32_10", 12'hB00, PRIV_M, 1'b1, 64'd10, 1'b0);
        applyStimulus("minstret_0", 12'hB02, PRIV_M, 1'b0, 64'd0, 1'b0);

        // Five retirements.
        for (int k = 0; k < 5; k++) begin
            InstrRetiredM = 1'b1;
            @(negedge clk);
        end
        InstrRetiredM = 1'b0;
        applyStimulus("minstret_5", 12'hB02, PRIV_M, 1'b0, 64'd5, 1'b0);
        applyStimulus("mcycle_15", 12'hB00, PRIV_M, 1'b0, 64'd15, 1'b0);

        // Inhibit counters 0 and 2 while hpm3 keeps counting events.
        MCOUNTINHIBIT_REGW = 32'h5;
        InstrRetiredM      = 1'b1;
        HPMEventM          = 32'h8;
        repeat (20) @(negedge clk);
        InstrRetiredM = 1'b0;
        HPMEventM     = '0;
        applyStimulus("inhibit_mcycle", 12'hB00, PRIV_M, 1'b0, 64'd15, 1'b0);
        applyStimulus("inhibit_minstret", 12'hB02, PRIV_M, 1'b0, 64'd5, 1'b0);
        applyStimulus("hpm3_events", 12'hB03, PRIV_M, 1'b0, 64'd20, 1'b0);
        applyStimulus("hpm3_hi32", 12'hB83, PRIV_M, 1'b1, 64'd0, 1'b0);
        MCOUNTINHIBIT_REGW = '0;
        @(negedge clk);
        applyStimulus("uninhibit_mcycle", 12'hB00, PRIV_M, 1'b0, 64'd16, 1'b0);

        // Write beats a simultaneous retirement.
        CSRWriteM        = 1'b1;
        UngatedCSRWriteM = 1'b1;
        CSRAdrM          = 12'hB02;
        CSRWriteValM     = 64'h100;
        InstrRetiredM    = 1'b1;
        @(negedge clk);
        CSRWriteM        = 1'b0;
        UngatedCSRWriteM = 1'b0;
        InstrRetiredM    = 1'b0;
        applyStimulus("write_prio", 12'hB02, PRIV_M, 1'b0, 64'h100, 1'b0);
        InstrRetiredM = 1'b1;
        @(negedge clk);
        InstrRetiredM = 1'b0;
        applyStimulus("write_then_retire", 12'hB02, PRIV_M, 1'b0, 64'h101, 1'b0);

        // RV32 halves and 64-bit wrap; on RV64 the 0xB80 write is illegal and dropped.
        CSRWriteM        = 1'b1;
        UngatedCSRWriteM = 1'b1;
        CSRAdrM          = 12'hB80;
        CSRWriteValM     = 64'hFFFF_FFFF;
        @(negedge clk);
        CSRAdrM      = 12'hB00;
        CSRWriteValM = 64'hFFFF_FFFE;
        @(negedge clk);
        CSRWriteM        = 1'b0;
        UngatedCSRWriteM = 1'b0;
        applyStimulus("rv32_hi_written", 12'hB80, PRIV_M, 1'b1, 64'hFFFF_FFFF, 1'b0);
        applyStimulus("rv32_lo_written", 12'hB00, PRIV_M, 1'b1, 64'hFFFF_FFFE, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus("rv32_wrap_lo", 12'hB00, PRIV_M, 1'b1, 64'h0, 1'b0);
        applyStimulus("rv32_wrap_hi", 12'hB80, PRIV_M, 1'b1, 64'h0, 1'b0);
        applyStimulus("rv64_carry32", 12'hB00, PRIV_M, 1'b0, 64'h1_0000_0000, 1'b0);

        // Privilege gating.
        @(negedge clk);
        MCOUNTEREN_REGW = 32'h1;
        SCOUNTEREN_REGW = 32'h0;
        applyStimulus("u_cycle_noscen", 12'hC00, PRIV_U, 1'b0, 64'h0, 1'b1);
        SCOUNTEREN_REGW = 32'h1;
        applyStimulus("u_cycle_ok", 12'hC00, PRIV_U, 1'b0, 64'h1_0000_0001, 1'b0);
        applyStimulus("s_cycle_ok", 12'hC00, PRIV_S, 1'b0, 64'h1_0000_0001, 1'b0);
        applyStimulus("s_mcycle_illegal", 12'hB00, PRIV_S, 1'b0, 64'h0, 1'b1);

        // Time shadows and read-only checks.
        @(negedge clk);
        applyStimulus("time64", 12'hC01, PRIV_M, 1'b0, 64'h1_2345_6789, 1'b0);
        applyStimulus("time32_lo", 12'hC01, PRIV_M, 1'b1, 64'h2345_6789, 1'b0);
        applyStimulus("time32_hi", 12'hC81, PRIV_M, 1'b1, 64'h1, 1'b0);
        applyStimulus("mtime_b01", 12'hB01, PRIV_M, 1'b0, 64'h0, 1'b1);
        @(negedge clk);
        CSRWriteM        = 1'b1;
        UngatedCSRWriteM = 1'b1;
        CSRWriteValM     = 64'hDEAD;
        applyStimulus("ro_write_c00", 12'hC00, PRIV_M, 1'b0, 64'h0, 1'b1);
        @(negedge clk);
        CSRWriteM        = 1'b0;
        UngatedCSRWriteM = 1'b0;
        applyStimulus("ro_not_written", 12'hB00, PRIV_M, 1'b0, 64'h1_0000_0004, 1'b0);

        // Freeze everything and sweep the decode/privilege table.
        MCOUNTINHIBIT_REGW = 32'hFFFF_FFFF;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            MCOUNTEREN_REGW  = vecs[i].mcen;
            SCOUNTEREN_REGW  = vecs[i].scen;
            UngatedCSRWriteM = vecs[i].ungated;
            applyStimulus($sformatf("vec%0d", i), vecs[i].adr, vecs[i].priv, vecs[i].rv32,
                          vecs[i].expVal, vecs[i].expIll);
        end
        UngatedCSRWriteM = 1'b0;

        // Reset in the middle of counting.
        @(negedge clk);
        MCOUNTINHIBIT_REGW = '0;
        reset              = 1'b1;
        @(negedge clk);
        applyStimulus("midreset_zero", 12'hB00, PRIV_M, 1'b0, 64'h0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus("midreset_resume64", 12'hB00, PRIV_M, 1'b0, 64'h1, 1'b0);
        applyStimulus("midreset_resume32", 12'hB00, PRIV_M, 1'b1, 64'h1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
